// File: rtl/lab2_issuer.sv
// lab2_issuer: start/rdy initiator that issues LFSR operands to a lab2 compute unit and queues the results
// Ports: clk/rst (async active-low) | go, seed: run control | start, x, rdy, y_in: compute-unit handshake
//        res_valid, res_data, res_pop: result FIFO (fall-through head) | busy, done, timeout_err, txn_cnt: status
//        sig: running result signature, present only when LAB2_ISSUER_SIG_EN is defined
module lab2_issuer #(
  parameter int N_TXN      = 8,
  parameter int TIMEOUT    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] seed,
  output logic        start,
  output logic [31:0] x,
  input  logic        rdy,
  input  logic [31:0] y_in,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_pop,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
`ifdef LAB2_ISSUER_SIG_EN
  output logic [31:0] sig,
`endif
  output logic [7:0]  txn_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_lfsr;
  logic [7:0]  r_timer, r_txn;
  logic        r_terr;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic        w_full, w_accept, w_push, w_pop, w_tmo, w_last;
  logic [31:0] w_lfsr_next;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_accept    = go && (r_state == S_IDLE || r_state == S_DONE);
  // rdy only counts in WAIT, so a response overlapping the start cycle is dropped
  assign w_push      = r_state == S_WAIT && rdy;
  assign w_pop       = res_pop && r_count != '0;
  assign w_tmo       = r_state == S_WAIT && !rdy && r_timer == 8'(TIMEOUT - 1);
  assign w_last      = r_txn == 8'(N_TXN - 1);
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);
  assign busy        = r_state == S_ISSUE || r_state == S_WAIT;
  assign done        = r_state == S_DONE;
  // the LFSR only advances when a result is accepted, so x holds through WAIT
  assign x           = busy ? r_lfsr : 32'h0;
  assign res_valid   = r_count != '0;
  assign res_data    = r_mem[r_rptr];
  assign timeout_err = r_terr;
  assign txn_cnt     = r_txn;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    start  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_next = go ? S_ISSUE : r_state;
      S_ISSUE: begin
        // a free FIFO slot is reserved before issuing so the push in WAIT can never overflow
        start  = !w_full;
        w_next = w_full ? S_ISSUE : S_WAIT;
      end
      S_WAIT: w_next = rdy ? (w_last ? S_DONE : S_ISSUE) : (w_tmo ? S_DONE : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_lfsr  <= 32'h1;
      r_timer <= '0;
      r_txn   <= '0;
      r_terr  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 32'h0;
    end else begin
      if (w_accept) begin
        r_lfsr  <= (seed == 32'h0) ? 32'h1 : seed;
        r_txn   <= '0;
        r_terr  <= 1'b0;
        r_timer <= '0;
      end
      if (start) r_timer <= '0;
      if (w_push) begin
        r_txn  <= r_txn + 8'd1;
        r_lfsr <= w_lfsr_next;
      end else if (w_tmo) r_terr <= 1'b1;
      else if (r_state == S_WAIT) r_timer <= r_timer + 8'd1;
      if (w_push) begin
        r_mem[r_wptr] <= y_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
`ifdef LAB2_ISSUER_SIG_EN
  logic [31:0] r_sig;
  assign sig = r_sig;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sig <= 32'h0;
    else if (w_accept) r_sig <= 32'h0;
    else if (w_push) r_sig <= {r_sig[30:0], r_sig[31]} ^ y_in;
`endif
endmodule

// File: tb/tb_lab2_issuer.sv
// tb_lab2_issuer: scoreboard bench for lab2_issuer with a 3-cycle y=x+1 responder
module tb_lab2_issuer;
  localparam int N_TXN = 8, TIMEOUT = 16;
  logic clk = 0, rst = 0, go = 0;
  logic [31:0] seed = 0;
  logic start, res_valid, busy, done, timeout_err;
  logic [31:0] x, res_data, y_in;
  logic [7:0] txn_cnt;
  logic rdy, res_pop;
  logic rdy_resp = 0, rdy_man = 0, pop_auto = 0, pop_man = 0;
  logic [31:0] y_resp = 0, y_man = 0;
`ifdef LAB2_ISSUER_SIG_EN
  logic [31:0] sig;
  logic [31:0] m_sig = 0;
`endif
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] xlog[$];
  logic [31:0] m_lfsr = 1;
  bit resp_en = 0, pop_en = 0;
  logic prev_start = 0;
  assign rdy = rdy_resp | rdy_man;
  assign y_in = rdy_man ? y_man : y_resp;
  assign res_pop = pop_auto | pop_man;
  lab2_issuer dut (
    .clk(clk), .rst(rst), .go(go), .seed(seed), .start(start), .x(x), .rdy(rdy), .y_in(y_in),
    .res_valid(res_valid), .res_data(res_data), .res_pop(res_pop), .busy(busy), .done(done),
    .timeout_err(timeout_err),
`ifdef LAB2_ISSUER_SIG_EN
    .sig(sig),
`endif
    .txn_cnt(txn_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] nxt(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction
  // responder: answers each observed start with y=x+1, rdy in the 3rd cycle after start
  initial begin
    logic [31:0] xv;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (prev_start && start) begin errors++; $display("FAIL start_twice: start=%b two cycles running, want 0", start); end
      end
      prev_start = start;
      if (resp_en && start) begin
        checks++;
        if (x !== m_lfsr) begin errors++; $display("FAIL issue_x: x=%h want %h", x, m_lfsr); end
        xv = x;
        xlog.push_back(xv);
        q.push_back(xv + 1);
        m_lfsr = nxt(m_lfsr);
        repeat (2) @(negedge clk);
        rdy_resp = 1; y_resp = xv + 1;
`ifdef LAB2_ISSUER_SIG_EN
        m_sig = {m_sig[30:0], m_sig[31]} ^ (xv + 1);
`endif
        @(posedge clk); #1 rdy_resp = 0;
        prev_start = 0;
      end
    end
  end
  // drainer: pops and compares the FIFO head whenever enabled
  initial forever begin
    @(negedge clk);
    pop_auto = 0;
    if (pop_en && res_valid) begin
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL pop_extra: res_data=%h with empty scoreboard", res_data); end
      else begin
        if (res_data !== q[0]) begin errors++; $display("FAIL res_data: got %h want %h", res_data, q[0]); end
        void'(q.pop_front());
      end
      pop_auto = 1;
    end
  end
  task automatic start_run(input logic [31:0] s);
    @(negedge clk);
    seed = s; go = 1; m_lfsr = (s == 0) ? 32'h1 : s;
`ifdef LAB2_ISSUER_SIG_EN
    m_sig = 0;
`endif
    @(negedge clk);
    go = 0;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin errors++; $display("FAIL %s_done: done=%b want 1 within 2000 cycles", nm, done); end
  endtask
  task automatic wait_txn(input int v);
    int n = 0;
    while (txn_cnt != 8'(v) && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (txn_cnt !== 8'(v)) begin errors++; $display("FAIL wait_txn: txn_cnt=%0d want %0d", txn_cnt, v); end
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((q.size() != 0 || res_valid) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0 || res_valid) begin errors++; $display("FAIL %s_drain: %0d left, res_valid=%b want 0", nm, q.size(), res_valid); end
  endtask
  task automatic check_reset_vals(input string nm);
    checks++;
    if ({start, busy, done, timeout_err, res_valid} !== 5'b0 || x !== 0 || txn_cnt !== 0 || res_data !== 0) begin
      errors++;
      $display("FAIL %s: start=%b busy=%b done=%b terr=%b rv=%b x=%h txn=%0d rd=%h want all 0",
               nm, start, busy, done, timeout_err, res_valid, x, txn_cnt, res_data);
    end
`ifdef LAB2_ISSUER_SIG_EN
    checks++;
    if (sig !== 0) begin errors++; $display("FAIL %s_sig: sig=%h want 0", nm, sig); end
`endif
  endtask
  task automatic test_reset;
    #1 check_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset_vals("reset_idle");
  endtask
  task automatic test_basic;
    pop_en = 1; resp_en = 1; xlog.delete();
    start_run(32'h1);
    wait_done("basic");
    checks++;
    if (txn_cnt !== 8'(N_TXN) || timeout_err !== 0 || busy !== 0) begin
      errors++; $display("FAIL basic_status: txn=%0d terr=%b busy=%b want %0d 0 0", txn_cnt, timeout_err, busy, N_TXN);
    end
    checks++;
    if (xlog.size() < 3 || xlog[0] !== 32'h1 || xlog[1] !== 32'h80200003 || xlog[2] !== 32'hC0300002) begin
      errors++; $display("FAIL basic_xseq: got %0d operands, first=%h want 1,80200003,C0300002", xlog.size(), xlog.size() ? xlog[0] : 32'hx);
    end
`ifdef LAB2_ISSUER_SIG_EN
    checks++;
    if (sig !== m_sig) begin errors++; $display("FAIL basic_sig: sig=%h want %h", sig, m_sig); end
`endif
    drain("basic");
  endtask
  task automatic test_seed0;
    xlog.delete();
    start_run(32'h0);
    wait_done("seed0");
    checks++;
    if (xlog.size() == 0 || xlog[0] !== 32'h1) begin errors++; $display("FAIL seed0_x: first x=%h want 00000001", xlog.size() ? xlog[0] : 32'hx); end
    drain("seed0");
  endtask
  task automatic test_backpressure;
    int starts = 0;
    pop_en = 0;
    start_run(32'h12345678);
    wait_txn(4);
    for (int i = 0; i < 10; i++) begin starts += int'(start); @(negedge clk); end
    checks++;
    if (starts != 0 || !res_valid || !busy) begin errors++; $display("FAIL bp_stall: starts=%0d rv=%b busy=%b want 0 1 1", starts, res_valid, busy); end
    checks++;
    if (res_data !== q[0]) begin errors++; $display("FAIL bp_pop: res_data=%h want %h", res_data, q[0]); end
    void'(q.pop_front());
    pop_man = 1;
    @(negedge clk);
    pop_man = 0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin starts += int'(start); @(negedge clk); end
    checks++;
    if (starts != 1 || txn_cnt !== 8'd5) begin errors++; $display("FAIL bp_one_issue: starts=%0d txn=%0d want 1 5", starts, txn_cnt); end
    pop_en = 1;
    wait_done("bp");
    drain("bp");
  endtask
  task automatic test_timeout;
    int n = 0;
    resp_en = 0;
    start_run(32'h7);
    checks++;
    if (start !== 1 || x !== 32'h7) begin errors++; $display("FAIL to_start: start=%b x=%h want 1 00000007", start, x); end
    while (!done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != TIMEOUT + 1 || timeout_err !== 1 || txn_cnt !== 0 || res_valid !== 0) begin
      errors++; $display("FAIL timeout: cycles=%0d terr=%b txn=%0d rv=%b want %0d 1 0 0", n, timeout_err, txn_cnt, res_valid, TIMEOUT + 1);
    end
  endtask
  task automatic test_spurious;
    @(negedge clk); rst = 0; @(negedge clk); rst = 1;
    rdy_man = 1; y_man = 32'hDEAD;
    @(negedge clk);
    rdy_man = 0;
    checks++;
    if (txn_cnt !== 0 || res_valid !== 0) begin errors++; $display("FAIL spur_idle: txn=%0d rv=%b want 0 0", txn_cnt, res_valid); end
    start_run(32'h9);
    rdy_man = 1;
    @(negedge clk);
    checks++;
    if (txn_cnt !== 0 || res_valid !== 0) begin errors++; $display("FAIL spur_start: txn=%0d rv=%b want 0 0", txn_cnt, res_valid); end
    y_man = 32'h1234;
    q.push_back(32'h1234);
    m_lfsr = nxt(32'h9);
    resp_en = 1; pop_en = 1;
    @(posedge clk); #1 rdy_man = 0;
    @(negedge clk);
    checks++;
    if (txn_cnt !== 8'd1) begin errors++; $display("FAIL spur_capture: txn=%0d want 1", txn_cnt); end
    wait_done("spur");
    checks++;
    if (txn_cnt !== 8'(N_TXN)) begin errors++; $display("FAIL spur_total: txn=%0d want %0d", txn_cnt, N_TXN); end
    drain("spur");
  endtask
  task automatic test_reset_mid;
    pop_en = 0;
    start_run(32'hABCD);
    wait_txn(2);
    @(negedge clk);
    checks++;
    if (busy !== 1 || start !== 0 || res_valid !== 1) begin errors++; $display("FAIL mid_pre: busy=%b start=%b rv=%b want 1 0 1", busy, start, res_valid); end
    @(posedge clk);
    #2 rst = 0;
    #1 check_reset_vals("reset_mid");
    resp_en = 0;
    repeat (5) @(negedge clk);
    q.delete();
    rst = 1;
    @(negedge clk);
    check_reset_vals("reset_mid_after");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_seed0();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lab2_issuer.md
Name: lab2_issuer

Overview:
- Initiator side of the lab2 start/rdy compute handshake.
- Generates a sequence of pseudo-random 32-bit operands and issues each one to a lab2 compute unit (multi-cycle or pipelined) with a one-cycle start pulse.
- Waits for rdy, captures each result into a small result FIFO, and flags hung transactions with a timeout.
- Sits between a host/bench controller and the compute unit; replaces hand-written start/x stimulus.

Parameters:
- N_TXN, 8, transactions per run (1..255).
- TIMEOUT, 16, max cycles in WAIT before abort (2..255).
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- go  input  1  run request; sampled only in IDLE or DONE.
- seed  input  32  LFSR seed, loaded on accepted go.
- start  output  1  one-cycle issue pulse to the compute unit.
- x  output  32  operand; stable from the start cycle until rdy is accepted.
- rdy  input  1  result-valid from the compute unit.
- y_in  input  32  result from the compute unit, valid when rdy=1.
- res_valid  output  1  FIFO not empty.
- res_data  output  32  FIFO head, valid when res_valid=1.
- res_pop  input  1  consume FIFO head; ignored when empty.
- busy  output  1  FSM in ISSUE or WAIT.
- done  output  1  FSM in DONE.
- timeout_err  output  1  sticky abort flag.
- txn_cnt  output  8  results captured in the current run.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE.
  - start=0, x=0, busy=0, done=0, timeout_err=0, txn_cnt=0.
  - LFSR=1, FIFO empty, res_valid=0, res_data=0, wait timer=0.
- LFSR: 32-bit Galois, right shift. next = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0). On go, seed=0 loads 1.
- IDLE / DONE:
  - go=1 loads the LFSR, clears txn_cnt, timeout_err and the timer, then moves to ISSUE.
  - FIFO contents are kept across runs.
  - DONE holds done=1 until go is accepted.
- ISSUE:
  - If FIFO count == FIFO_DEPTH, stall: start=0, state held.
  - Else: start=1 and x=lfsr for exactly this cycle; next state WAIT; timer cleared.
  - start is never high for two consecutive cycles.
- WAIT:
  - rdy is accepted from the first cycle after start; rdy during the start cycle or outside WAIT is ignored.
  - Timer increments each cycle without rdy. If the timer reaches TIMEOUT: timeout_err=1, go to DONE, nothing pushed.
  - On rdy=1:
    - push y_in into the FIFO; txn_cnt++; LFSR advances.
    - if txn_cnt (pre-increment) == N_TXN-1, go to DONE; else go to ISSUE.
    - The FIFO cannot be full here because ISSUE guarantees a free slot.
- FIFO:
  - Registered head, first-word fall-through.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Minimum issue interval is 2 cycles (ISSUE→WAIT with rdy on the first WAIT cycle→ISSUE).
- go while busy is ignored.
- Reset mid-run aborts immediately to the reset values; the compute unit is not notified.

Optional Feature:
- Macro: LAB2_ISSUER_SIG_EN.
- When defined:
  - Adds output sig[31:0], reset 0, cleared on accepted go.
  - Each captured result updates sig = {sig[30:0],sig[31]} ^ y_in in the push cycle.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, seed=0x00000001, go; responder returns y=x+1 after 3 cycles.
  - x sequence 0x00000001, 0x80200003, 0xC0300002, …
  - FIFO receives 0x00000002, 0x80200004, …
  - done after 8 results, txn_cnt=8, timeout_err=0.
- seed=0 -> first x=0x00000001 (same as seed 1).
- Backpressure: res_pop held 0.
  - After 4 results, start stays 0 in ISSUE.
  - Single res_pop -> exactly one new start follows.
- Timeout: responder never asserts rdy.
  - 16 cycles after start: timeout_err=1, done=1, txn_cnt=0, FIFO empty.
- Spurious rdy: rdy=1 in the start cycle and in IDLE.
  - No push, txn_cnt unchanged.
  - rdy on the next cycle is captured.
- rst=0 asserted mid-WAIT.
  - All outputs return to reset values asynchronously, before the next clk edge.
  - With LAB2_ISSUER_SIG_EN, sig=0.
